// File: rtl/fg_sram_arbiter_pkg.sv
// Shared constants and address helpers for the foreground SRAM arbiter.
// Addresses are row-major words: y * width + x.
package fg_sram_arbiter_pkg;

    localparam int FG_PRECISION    = 11;
    localparam int FG_PIXEL_SIZE   = 16;
    localparam int FG_RESOLUTION_X = 800;
    localparam int FG_RESOLUTION_Y = 600;
    localparam int FG_ADDR_WIDTH   = 19;

    // Full-width word address; callers truncate to their address width.
    function automatic int fg_addr(input int x, input int y, input int res_x);
        return y * res_x + x;
    endfunction

    // Signed bounds check so negative request coordinates land out of range.
    function automatic logic fg_in_range(input int x, input int y,
                                         input int res_x, input int res_y);
        return (x >= 0) && (x < res_x) && (y >= 0) && (y < res_y);
    endfunction

endpackage

// File: rtl/fg_write_fifo.sv
// Synchronous FIFO for buffered foreground writes; head word is visible on
// dout while not empty, so a pop consumes it in the same cycle.
module fg_write_fifo
    import fg_sram_arbiter_pkg::*;
#(
    parameter int WIDTH = FG_ADDR_WIDTH + FG_PIXEL_SIZE,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/fg_sram_arbiter.sv
// Shares the foreground SRAM: fixed-latency prioritised reads from the
// compositing pipeline, FIFO-buffered capture writes drained into idle slots.
module fg_sram_arbiter
    import fg_sram_arbiter_pkg::*;
#(
    parameter int PRECISION         = FG_PRECISION,
    parameter int PIXEL_SIZE        = FG_PIXEL_SIZE,
    parameter int RESOLUTION_X      = FG_RESOLUTION_X,
    parameter int RESOLUTION_Y      = FG_RESOLUTION_Y,
    parameter int ADDR_WIDTH        = FG_ADDR_WIDTH,
    parameter int SRAM_READ_LATENCY = 2,
    parameter int RESPONSE_DELAY    = 5,
    parameter int WR_FIFO_DEPTH     = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rd_valid,
    input  logic                              rd_active,
    input  logic [PRECISION:0]                rd_x,
    input  logic [PRECISION:0]                rd_y,
    output logic [PIXEL_SIZE-1:0]             rd_pixel,
    output logic                              rd_skip,
    output logic                              rd_ready,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic [PRECISION-1:0]              wr_x,
    input  logic [PRECISION-1:0]              wr_y,
    input  logic [PIXEL_SIZE-1:0]             wr_pixel,
    output logic                              wr_dropped,
    output logic [$clog2(WR_FIFO_DEPTH):0]    fifo_level,
    output logic                              sram_en,
    output logic                              sram_we,
    output logic [ADDR_WIDTH-1:0]             sram_addr,
    output logic [PIXEL_SIZE-1:0]             sram_wdata,
    input  logic [PIXEL_SIZE-1:0]             sram_rdata
);

    localparam int FIFO_W     = ADDR_WIDTH + PIXEL_SIZE;
    // tag/hit stages from S2 up to the edge that samples sram_rdata
    localparam int TAG_STAGES = SRAM_READ_LATENCY + 1;
    // response stages after capture; RESPONSE_DELAY >= SRAM_READ_LATENCY + 3
    localparam int PAD_STAGES = RESPONSE_DELAY - SRAM_READ_LATENCY - 2;

    logic                  rd_in_range;
    logic                  wr_in_range;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] wr_addr;

    assign rd_in_range = fg_in_range(int'($signed(rd_x)), int'($signed(rd_y)),
                                     RESOLUTION_X, RESOLUTION_Y);
    assign wr_in_range = fg_in_range(int'(wr_x), int'(wr_y), RESOLUTION_X, RESOLUTION_Y);
    assign rd_addr = ADDR_WIDTH'(fg_addr(int'($signed(rd_x)), int'($signed(rd_y)), RESOLUTION_X));
    assign wr_addr = ADDR_WIDTH'(fg_addr(int'(wr_x), int'(wr_y), RESOLUTION_X));

    // Write handshake: a beat transfers on a cycle where wr_valid & wr_ready;
    // wr_ready depends only on FIFO fullness and rst, never on wr_valid.
    logic              wr_fire;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FIFO_W-1:0] fifo_dout;

    assign wr_ready  = ~fifo_full & ~rst;
    assign wr_fire   = wr_valid & wr_ready;
    assign fifo_push = wr_fire & wr_in_range;

    fg_write_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (WR_FIFO_DEPTH)
    ) u_write_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   ({wr_addr, wr_pixel}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) wr_dropped <= 1'b0;
        else if (wr_fire & ~wr_in_range) wr_dropped <= 1'b1;
    end

    // S1: registered read slot
    logic                  s1_tag;
    logic                  s1_hit;
    logic [ADDR_WIDTH-1:0] s1_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_tag  <= 1'b0;
            s1_hit  <= 1'b0;
            s1_addr <= '0;
        end else begin
            s1_tag  <= rd_valid;
            s1_hit  <= rd_valid & rd_active & rd_in_range;
            s1_addr <= rd_addr;
        end
    end

    // S2 issue: a read hit always owns the slot, otherwise drain one write.
    assign fifo_pop = ~s1_hit & ~fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            sram_en    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else if (s1_hit) begin
            sram_en    <= 1'b1;
            sram_we    <= 1'b0;
            sram_addr  <= s1_addr;
            sram_wdata <= '0;
        end else if (!fifo_empty) begin
            sram_en    <= 1'b1;
            sram_we    <= 1'b1;
            sram_addr  <= fifo_dout[FIFO_W-1:PIXEL_SIZE];
            sram_wdata <= fifo_dout[PIXEL_SIZE-1:0];
        end else begin
            sram_en    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end
    end

    // Response delay line: tag/hit ride alongside the SRAM access, data joins
    // at the capture edge, then pads out to the fixed response latency.
    logic [TAG_STAGES-1:0] tag_pipe;
    logic [TAG_STAGES-1:0] hit_pipe;
    logic                  resp_tag  [PAD_STAGES];
    logic                  resp_skip [PAD_STAGES];
    logic [PIXEL_SIZE-1:0] resp_data [PAD_STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_pipe <= '0;
            hit_pipe <= '0;
            for (int i = 0; i < PAD_STAGES; i++) begin
                resp_tag[i]  <= 1'b0;
                resp_skip[i] <= 1'b0;
                resp_data[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= s1_tag;
            hit_pipe[0] <= s1_hit;
            for (int i = 1; i < TAG_STAGES; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
                hit_pipe[i] <= hit_pipe[i-1];
            end
            resp_tag[0]  <= tag_pipe[TAG_STAGES-1];
            resp_skip[0] <= tag_pipe[TAG_STAGES-1] & ~hit_pipe[TAG_STAGES-1];
            resp_data[0] <= hit_pipe[TAG_STAGES-1] ? sram_rdata : '0;
            for (int i = 1; i < PAD_STAGES; i++) begin
                resp_tag[i]  <= resp_tag[i-1];
                resp_skip[i] <= resp_skip[i-1];
                resp_data[i] <= resp_data[i-1];
            end
        end
    end

    assign rd_ready = resp_tag[PAD_STAGES-1];
    assign rd_skip  = resp_skip[PAD_STAGES-1];
    assign rd_pixel = resp_data[PAD_STAGES-1];

endmodule

// File: tb/tb_fg_sram_arbiter.sv
// Bench for fg_sram_arbiter: SRAM model, cycle-indexed reference scoreboard,
// directed scenarios followed by randomized traffic.
module tb_fg_sram_arbiter;

    localparam int RES_X = 800;
    localparam int RES_Y = 600;
    localparam int DEPTH = 16;
    localparam int RESP  = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        rd_valid, rd_active;
    logic [11:0] rd_x, rd_y;
    logic [15:0] rd_pixel;
    logic        rd_skip, rd_ready;
    logic        wr_valid, wr_ready;
    logic [10:0] wr_x, wr_y;
    logic [15:0] wr_pixel;
    logic        wr_dropped;
    logic [4:0]  fifo_level;
    logic        sram_en, sram_we;
    logic [18:0] sram_addr;
    logic [15:0] sram_wdata, sram_rdata;

    fg_sram_arbiter dut (
        .clk(clk), .rst(rst),
        .rd_valid(rd_valid), .rd_active(rd_active), .rd_x(rd_x), .rd_y(rd_y),
        .rd_pixel(rd_pixel), .rd_skip(rd_skip), .rd_ready(rd_ready),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
        .wr_pixel(wr_pixel), .wr_dropped(wr_dropped), .fifo_level(fifo_level),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // ---------------- SRAM model (2-cycle read latency) ----------------
    logic [15:0] mem [int];
    logic [15:0] rpipe0 = 16'h0, rpipe1 = 16'h0;

    function automatic logic [15:0] init_val(input logic [18:0] a);
        return (a == 19'd1610) ? 16'hABCD : (a[15:0] ^ 16'h5A5A);
    endfunction

    always @(posedge clk) begin
        if (sram_en && sram_we) mem[int'(sram_addr)] = sram_wdata;
        rpipe1 <= rpipe0;
        if (sram_en && !sram_we)
            rpipe0 <= mem.exists(int'(sram_addr)) ? mem[int'(sram_addr)] : init_val(sram_addr);
        else
            rpipe0 <= 16'hDEAD;
    end
    assign sram_rdata = rpipe1;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference scoreboard ----------------
    typedef struct { int cyc; logic skip; logic [15:0] pix; } rd_exp_t;
    typedef struct { int cyc; logic [18:0] addr; } iss_t;

    rd_exp_t     rd_q[$];
    iss_t        iss_q[$];
    logic [34:0] exp_q[$];
    int          exp_cyc_q[$];
    bit          drop_model = 1'b0;
    bit          mon_en = 1'b0;
    int          cyc = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            int  x, y, a;
            bit  hit;
            rd_exp_t r;
            iss_t    s;
            cyc++;
            if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
                r = rd_q.pop_front();
                check_eq("rd_ready", rd_ready, 1);
                check_eq("rd_skip", rd_skip, r.skip);
                check_eq("rd_pixel", rd_pixel, r.pix);
            end else begin
                check_eq("rd_ready_idle", rd_ready, 0);
            end
            if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
                s = iss_q.pop_front();
                check_eq("rd_issue_en_we", {sram_en, sram_we}, 2'b10);
                check_eq("rd_issue_addr", sram_addr, s.addr);
            end else if (exp_q.size() > 0 && exp_cyc_q[0] <= cyc - 2) begin
                check_eq("wr_issue_en_we", {sram_en, sram_we}, 2'b11);
                check_eq("wr_issue_addr_data", {sram_addr, sram_wdata}, exp_q[0]);
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end else begin
                check_eq("sram_idle", sram_en, 0);
            end
            check_eq("fifo_level", fifo_level, exp_q.size());
            check_eq("wr_ready", wr_ready, (!rst && exp_q.size() < DEPTH));
            check_eq("wr_dropped", wr_dropped, drop_model);
            if (rst) begin
                rd_q.delete(); iss_q.delete(); exp_q.delete(); exp_cyc_q.delete();
                drop_model = 1'b0;
            end else begin
                if (rd_valid) begin
                    x = int'($signed(rd_x));
                    y = int'($signed(rd_y));
                    hit = rd_active && x >= 0 && x < RES_X && y >= 0 && y < RES_Y;
                    a = y * RES_X + x;
                    r.cyc = cyc + RESP; r.skip = !hit; r.pix = hit ? init_val(19'(a)) : 16'h0;
                    rd_q.push_back(r);
                    if (hit) begin
                        s.cyc = cyc + 2; s.addr = 19'(a);
                        iss_q.push_back(s);
                    end
                end
                if (wr_valid && wr_ready) begin
                    if (int'(wr_x) < RES_X && int'(wr_y) < RES_Y) begin
                        a = int'(wr_y) * RES_X + int'(wr_x);
                        exp_q.push_back({19'(a), wr_pixel});
                        exp_cyc_q.push_back(cyc);
                    end else begin
                        drop_model = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    logic [37:0] wp_q[$];   // pending writes {x, y, pixel}
    int acc_cnt = 0;

    task automatic run_cycle(input bit rv, input bit ra, input int rx, input int ry);
        rd_valid = rv; rd_active = ra; rd_x = 12'(rx); rd_y = 12'(ry);
        if (wp_q.size() > 0) begin
            wr_valid = 1'b1;
            {wr_x, wr_y, wr_pixel} = wp_q[0];
        end else begin
            wr_valid = 1'b0;
        end
        @(negedge clk);
        if (wr_valid && wr_ready && !rst) begin
            void'(wp_q.pop_front());
            acc_cnt++;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(0, 0, 0, 0);
    endtask

    function automatic logic [37:0] wr_item(input int x, input int y, input int p);
        return {11'(x), 11'(y), 16'(p)};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        rd_valid = 0; rd_active = 0; rd_x = '0; rd_y = '0;
        wr_valid = 0; wr_x = '0; wr_y = '0; wr_pixel = '0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);

        // single read hit at (10,2), then skip slots
        run_cycle(1, 1, 10, 2);
        idle(7);
        run_cycle(1, 0, 10, 2);
        idle(6);
        run_cycle(1, 1, -1, 5);
        idle(6);
        run_cycle(1, 1, 3, 600);
        idle(6);

        // a queued write takes the slot of a skipped read between hits
        wp_q.push_back(wr_item(5, 400, 16'h7777));
        for (int i = 0; i < 4; i++) run_cycle(1, 1, i, 1);
        run_cycle(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) run_cycle(1, 1, i, 3);
        idle(8);

        // write into an idle SRAM at the last pixel
        wp_q.push_back(wr_item(799, 599, 16'h1234));
        idle(6);

        // overflow: continuous hits block the drain while writes pile up
        acc_cnt = 0;
        for (int i = 0; i < 20; i++) wp_q.push_back(wr_item(i, 300 + i, 16'hC000 + i));
        for (int i = 0; i < 800; i++)
            run_cycle(1, 1, $urandom_range(0, RES_X - 1), $urandom_range(0, 299));
        check_eq("overflow_accepted", acc_cnt, DEPTH);
        wp_q.delete();
        idle(25);

        // interleave: reads every other cycle with 4 writes queued
        for (int i = 0; i < 4; i++) wp_q.push_back(wr_item(100 + i, 500, 16'hB000 + i));
        for (int i = 0; i < 20; i++) run_cycle(i % 2 == 0, 1, 50 + i, 7);
        idle(8);

        // randomized mixed traffic
        for (int i = 0; i < 2000; i++) begin
            int rx, ry;
            if (wp_q.size() < 3 && $urandom_range(0, 99) < 40) begin
                wp_q.push_back(wr_item($urandom_range(0, 810), $urandom_range(300, 610),
                                       $urandom_range(0, 16'hFFFF)));
            end
            rx = $urandom_range(0, 99) < 5 ? -int'($urandom_range(1, 3)) : $urandom_range(0, 805);
            ry = $urandom_range(0, 99) < 5 ? $urandom_range(600, 610) : $urandom_range(0, 299);
            run_cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 80, rx, ry);
        end
        wp_q.delete();
        idle(30);

        // reset mid-flight: 3 read slots in flight, writes queued
        for (int i = 0; i < 5; i++) wp_q.push_back(wr_item(i, 450, 16'hE000 + i));
        for (int i = 0; i < 3; i++) run_cycle(1, 1, 20 + i, 9);
        idle(1);
        rst = 1'b1;
        run_cycle(0, 0, 0, 0);
        rst = 1'b0;
        wp_q.delete();
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fg_sram_arbiter.md
Name: fg_sram_arbiter

Overview:
- Shares the single foreground SRAM between two requesters: the compositing pipeline's foreground pixel reads and the foreground capture path's pixel writes.
- Reads are strictly prioritised and answered at a fixed, parameterised latency, which the compositing pipeline's foreground fetch contract requires.
- Writes are buffered in a FIFO and drained into idle SRAM slots, such as skipped reads and blanking.
- Sits between the pipeline's foreground request ports, the capture writer and the SRAM controller pins.

Parameters:
- PRECISION, 11, coordinate width; request coordinates are signed PRECISION+1.
- PIXEL_SIZE, 16, pixel width (RGB565).
- RESOLUTION_X, 800, foreground frame width.
- RESOLUTION_Y, 600, foreground frame height.
- ADDR_WIDTH, 19, SRAM word address width.
- SRAM_READ_LATENCY, 2, cycles from the read issue edge to valid sram_rdata.
- RESPONSE_DELAY, 5, cycles from rd_valid sampled to rd_ready; must be >= SRAM_READ_LATENCY+3.
- WR_FIFO_DEPTH, 16, write FIFO entries; power of two.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- rd_valid  in  1  read slot present this cycle; a response is always returned.
- rd_active  in  1  requester wants a pixel (fg_pixel_request_active).
- rd_x  in  PRECISION+1  signed foreground x.
- rd_y  in  PRECISION+1  signed foreground y.
- rd_pixel  out  PIXEL_SIZE  returned pixel.
- rd_skip  out  1  no pixel for this slot.
- rd_ready  out  1  response strobe (fg_pixel_ready).
- wr_valid  in  1  write request.
- wr_ready  out  1  FIFO can accept.
- wr_x  in  PRECISION  write x.
- wr_y  in  PRECISION  write y.
- wr_pixel  in  PIXEL_SIZE  write data.
- wr_dropped  out  1  sticky: an out-of-range write was discarded.
- fifo_level  out  $clog2(WR_FIFO_DEPTH)+1  current FIFO occupancy.
- sram_en  out  1  SRAM access this cycle.
- sram_we  out  1  1 = write, 0 = read.
- sram_addr  out  ADDR_WIDTH  word address.
- sram_wdata  out  PIXEL_SIZE  write data.
- sram_rdata  in  PIXEL_SIZE  read data.

Behaviour:
- Reset state (synchronous rst): all outputs 0, FIFO emptied, response delay line cleared, wr_dropped cleared. Reset mid-operation discards in-flight reads: no rd_ready pulse for slots sampled before rst. wr_ready is 0 while rst is high and 1 in the first cycle after.
- Address: addr = y*RESOLUTION_X + x, computed at full width and truncated to ADDR_WIDTH.
- In range means 0 <= x < RESOLUTION_X and 0 <= y < RESOLUTION_Y, with signed compare for reads.
- Read path, slot sampled at cycle t:
  - S1 (t+1): register addr, hit = rd_valid & rd_active & in_range, and tag = rd_valid.
  - S2 (t+2): if hit, drive sram_en=1, sram_we=0, sram_addr. These are registered outputs.
  - sram_rdata is sampled at edge t+2+SRAM_READ_LATENCY.
  - A tag/hit/data delay line is padded so that rd_ready=1 exactly at t+RESPONSE_DELAY.
  - The response is rd_skip=~hit; rd_pixel = data if hit, else 0.
  - Slots with rd_valid=0 produce no rd_ready.
  - Back-to-back rd_valid every cycle is fully supported, with one response per cycle in order.
- Write path:
  - Push when wr_valid & wr_ready.
  - An out-of-range write is accepted but not stored, and sets wr_dropped.
  - FIFO entries store the computed address and the pixel.
  - wr_ready = ~full. There is no pass-through on full; a push and pop in the same cycle while full is impossible because wr_ready=0.
  - Simultaneous push and pop when not full leaves fifo_level unchanged.
- Arbitration, per S2 cycle:
  - An S1 hit always wins.
  - Otherwise, if the FIFO is not empty, pop the head and drive sram_en=1, sram_we=1, sram_addr, sram_wdata for one cycle.
  - If the FIFO is empty, sram_en=0.
  - A write issued in the cycle immediately before or after a read needs no turnaround cycle.
- Starvation: continuous hits block writes indefinitely. This is intentional; blanking provides drain slots. The FIFO fills and wr_ready deasserts.
- fifo_level is the registered occupancy: 0 when empty, WR_FIFO_DEPTH when full.

Decomposition:
- Shared package:
  - PIXEL_SIZE and ADDR_WIDTH.
  - Resolution constants.
  - An address-compute function.
  - A signed in-range check function.
- Sub-module fg_write_fifo: synchronous FIFO with parameterised width and depth, exposing full, empty and level; its reset is the same synchronous rst.
- The arbiter proper holds the S1/S2 registers, the issue mux and the response delay line.

Test Plan:
- Read latency and skip cases (rst released, FIFO empty): single rd_valid with rd_active=1 at x=10, y=2; then separate rd_valid slots with rd_active=0, with x=-1, and with y=600. -> Read: sram_addr=1610, we=0 at t+2; sram_rdata=16'hABCD returned; rd_ready=1 with rd_pixel=ABCD and rd_skip=0 exactly 5 cycles after rd_valid. Skip slots: rd_ready at +5 with rd_skip=1 and rd_pixel=0, no sram_en in their S2 cycle, and a queued write issued in that slot instead.
- Write in idle: wr_valid at x=799, y=599, pixel 16'h1234, no reads. -> sram_en=1, we=1, addr=479999, wdata=1234 within 3 cycles; fifo_level back to 0.
- Overflow: 800 consecutive read hits plus 20 writes. -> wr_ready falls at fifo_level=16, no write issued during the hits, FIFO drains one entry per cycle after the reads stop, the 16 accepted writes appear in order, and no read response is lost.
- Interleave: reads every other cycle with 4 queued writes. -> Writes occupy the alternate slots, and read responses keep the fixed 5-cycle latency.
- Reset mid-flight: rst asserted 2 cycles after 3 read slots with 5 writes queued. -> No rd_ready pulses, fifo_level=0, sram_en=0 the cycle after rst, wr_dropped=0.
